// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: scoreboard slot layout,
// memory-wait FSM states and the register-index width.
package pipeline_hazard_sequencer_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] regIdx_t;

    typedef struct packed {
        regIdx_t dest;
        logic    wbEn;
        logic    memRead;
        logic    memWrite;
        logic    s;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // True when the slot's instruction writes a register the ID instruction reads.
    function automatic logic readsDest(slot_t p, regIdx_t src1, regIdx_t src2, logic twoSrc);
        return p.wbEn && ((p.dest == src1) || (twoSrc && (p.dest == src2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Control bus between the pipeline datapath (master) and the hazard sequencer (slave).
// memReq/memReady: memReq stays high for every WAIT cycle; the access completes in the first
// such cycle that samples memReady high (or at timeout); memReady is ignored while memReq is low.
interface pipeline_hazard_sequencer_if;
    import pipeline_hazard_sequencer_pkg::*;

    logic        idValid;
    regIdx_t     idSrc1;
    regIdx_t     idSrc2;
    logic        idTwoSrc;
    logic        idUsesFlags;
    regIdx_t     idDest;
    logic        idWbEn;
    logic        idMemRead;
    logic        idMemWrite;
    logic        idS;
    logic        exBranchTaken;
    logic        memReady;

    logic        freezeIF;
    logic        flushIF;
    logic        flushID;
    logic        stallAll;
    logic        memReq;
    logic        memErr;
    logic [15:0] stallCount;
    memState_t   memState;

    modport master (
        output idValid, idSrc1, idSrc2, idTwoSrc, idUsesFlags, idDest,
               idWbEn, idMemRead, idMemWrite, idS, exBranchTaken, memReady,
        input  freezeIF, flushIF, flushID, stallAll, memReq, memErr, stallCount, memState
    );

    modport slave (
        input  idValid, idSrc1, idSrc2, idTwoSrc, idUsesFlags, idDest,
               idWbEn, idMemRead, idMemWrite, idS, exBranchTaken, memReady,
        output freezeIF, flushIF, flushID, stallAll, memReq, memErr, stallCount, memState
    );

endinterface

// File: rtl/pipeline_hazard_sequencer_mem_wait.sv
// Data-memory wait FSM: one IDLE entry cycle per access, then WAIT until memReady
// or until MEM_TIMEOUT WAIT cycles have elapsed (which sets the sticky memErr).
module mem_wait_fsm
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      memOp,
    input  logic      memReady,
    output logic      memReq,
    output logic      memStall,
    output logic      memErr,
    output memState_t state
);

    localparam int            CW   = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    memState_t     nextState;
    logic [CW-1:0] waitCnt;
    logic          timeout;

    assign timeout = (state == WAIT) && !memReady && (waitCnt == LAST);

    // The counter is held at zero in IDLE, so every WAIT visit starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : '0;
            if (timeout) begin
                memErr <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (memOp) nextState = WAIT;
            WAIT: if (memReady || timeout) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        memReq   = 1'b0;
        memStall = 1'b0;
        case (state)
            IDLE: memStall = memOp;
            WAIT: begin
                memReq   = 1'b1;
                memStall = !memReady && !timeout;
            end
            default: begin
                memReq   = 1'b0;
                memStall = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: EX/MEM shadow scoreboard, RAW and flag hazard detection,
// branch flush and memory-wait stall priority for the five-stage pipeline registers.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 16
)
(
    input logic                        clk,
    input logic                        rst,
    pipeline_hazard_sequencer_if.slave bus
);

    slot_t       exSlot;
    slot_t       memSlot;
    slot_t       idSlot;
    logic        hitEx;
    logic        hitMem;
    logic        rawHaz;
    logic        flagHaz;
    logic        hazard;
    logic        memOp;
    logic        memStall;
    logic        memReqRaw;
    logic        memErr;
    memState_t   memState;
    logic        pipeStall;
    logic        pipeFreeze;
    logic        pipeFlushIF;
    logic        pipeFlushID;
    logic [15:0] stallCount;
    logic        unusedMemS;

    assign idSlot = '{dest:     bus.idDest,
                      wbEn:     bus.idWbEn,
                      memRead:  bus.idMemRead,
                      memWrite: bus.idMemWrite,
                      s:        bus.idS};

    assign hitEx   = readsDest(exSlot, bus.idSrc1, bus.idSrc2, bus.idTwoSrc);
    assign hitMem  = readsDest(memSlot, bus.idSrc1, bus.idSrc2, bus.idTwoSrc);
    // With forwarding only a load in EX cannot be bypassed in time.
    assign rawHaz  = FWD_EN ? (hitEx && exSlot.memRead) : (hitEx || hitMem);
    assign flagHaz = bus.idUsesFlags && exSlot.s;
    assign hazard  = bus.idValid && (rawHaz || flagHaz);
    assign memOp   = memSlot.memRead || memSlot.memWrite;

    // Flags are consumed from EX only; the MEM copy of s is carried for slot symmetry.
    assign unusedMemS = memSlot.s;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemWait (
        .clk      (clk),
        .rst      (rst),
        .memOp    (memOp),
        .memReady (bus.memReady),
        .memReq   (memReqRaw),
        .memStall (memStall),
        .memErr   (memErr),
        .state    (memState)
    );

    always_comb begin
        pipeStall   = 1'b0;
        pipeFreeze  = 1'b0;
        pipeFlushIF = 1'b0;
        pipeFlushID = 1'b0;
        if (memStall) begin
            pipeStall  = 1'b1;
            pipeFreeze = 1'b1;
        end else if (bus.exBranchTaken) begin
            pipeFlushIF = 1'b1;
            pipeFlushID = 1'b1;
        end else if (hazard) begin
            pipeFreeze  = 1'b1;
            pipeFlushID = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exSlot  <= BUBBLE;
            memSlot <= BUBBLE;
        end else if (!pipeStall) begin
            memSlot <= exSlot;
            exSlot  <= (pipeFlushID || !bus.idValid) ? BUBBLE : idSlot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= '0;
        end else if (pipeFreeze && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.stallAll   = rst & pipeStall;
    assign bus.freezeIF   = rst & pipeFreeze;
    assign bus.flushIF    = rst & pipeFlushIF;
    assign bus.flushID    = rst & pipeFlushID;
    assign bus.memReq     = rst & memReqRaw;
    assign bus.memErr     = memErr;
    assign bus.stallCount = stallCount;
    assign bus.memState   = memState;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: two instances (forwarding on / off, timeout 4)
// share stimulus and are compared each cycle against a cycle-count model of the pipeline.
module tb_pipeline_hazard_sequencer;

    localparam int TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic       idValid;
    logic [3:0] idSrc1;
    logic [3:0] idSrc2;
    logic [3:0] idDest;
    logic       idTwoSrc;
    logic       idUsesFlags;
    logic       idWbEn;
    logic       idMemRead;
    logic       idMemWrite;
    logic       idS;
    logic       exBranchTaken;
    logic       memReady;

    int nChecks = 0;
    int nPass   = 0;
    int cycleNo = 0;

    pipeline_hazard_sequencer_if busA ();
    pipeline_hazard_sequencer_if busB ();

    assign busA.idValid       = idValid;
    assign busA.idSrc1        = idSrc1;
    assign busA.idSrc2        = idSrc2;
    assign busA.idTwoSrc      = idTwoSrc;
    assign busA.idUsesFlags   = idUsesFlags;
    assign busA.idDest        = idDest;
    assign busA.idWbEn        = idWbEn;
    assign busA.idMemRead     = idMemRead;
    assign busA.idMemWrite    = idMemWrite;
    assign busA.idS           = idS;
    assign busA.exBranchTaken = exBranchTaken;
    assign busA.memReady      = memReady;
    assign busB.idValid       = idValid;
    assign busB.idSrc1        = idSrc1;
    assign busB.idSrc2        = idSrc2;
    assign busB.idTwoSrc      = idTwoSrc;
    assign busB.idUsesFlags   = idUsesFlags;
    assign busB.idDest        = idDest;
    assign busB.idWbEn        = idWbEn;
    assign busB.idMemRead     = idMemRead;
    assign busB.idMemWrite    = idMemWrite;
    assign busB.idS           = idS;
    assign busB.exBranchTaken = exBranchTaken;
    assign busB.memReady      = memReady;

    pipeline_hazard_sequencer #(.FWD_EN(1'b1), .MEM_TIMEOUT(TIMEOUT)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    pipeline_hazard_sequencer #(.FWD_EN(1'b0), .MEM_TIMEOUT(TIMEOUT)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s dut%s cycle %0d: got %0h, expected %0h",
                      name, (k == 0) ? "A" : "B", cycleNo, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] dest;
        logic       wbEn;
        logic       memRead;
        logic       memWrite;
        logic       s;
    } tbSlot_t;

    tbSlot_t mEx  [2] = '{default: '0};
    tbSlot_t mMem [2] = '{default: '0};
    int      mPhase[2] = '{default: 0};   // cycles the current MEM memory op has already spent in MEM
    bit      mErr [2] = '{default: 0};
    int      mCnt [2] = '{default: 0};

    function automatic bit readsR(tbSlot_t p);
        return p.wbEn && ((p.dest == idSrc1) || (idTwoSrc && (p.dest == idSrc2)));
    endfunction

    logic        aFreeze, aFlushIF, aFlushID, aStall, aReq, aErr;
    logic [15:0] aCnt;
    bit          eFreeze, eFlushIF, eFlushID, eStall, eReq, eErr;
    int          eCnt;
    bit          memOpM, doneM, tmoM, hitExM, hitMemM, rawM, hazM;
    tbSlot_t     idSl;

    always @(negedge clk) begin
        cycleNo++;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                aFreeze = busA.freezeIF; aFlushIF = busA.flushIF; aFlushID = busA.flushID;
                aStall = busA.stallAll; aReq = busA.memReq; aErr = busA.memErr; aCnt = busA.stallCount;
            end else begin
                aFreeze = busB.freezeIF; aFlushIF = busB.flushIF; aFlushID = busB.flushID;
                aStall = busB.stallAll; aReq = busB.memReq; aErr = busB.memErr; aCnt = busB.stallCount;
            end
            eFreeze = 0; eFlushIF = 0; eFlushID = 0; eStall = 0; eReq = 0; tmoM = 0; memOpM = 0;
            if (!rst) begin
                mEx[k] = '0; mMem[k] = '0; mPhase[k] = 0; mErr[k] = 0; mCnt[k] = 0;
                eErr = 0; eCnt = 0;
            end else begin
                memOpM  = mMem[k].memRead || mMem[k].memWrite;
                eReq    = memOpM && (mPhase[k] >= 1);
                doneM   = eReq && (memReady || (mPhase[k] == TIMEOUT));
                tmoM    = eReq && !memReady && (mPhase[k] == TIMEOUT);
                eStall  = memOpM && !doneM;
                hitExM  = readsR(mEx[k]);
                hitMemM = readsR(mMem[k]);
                rawM    = (k == 0) ? (hitExM && mEx[k].memRead) : (hitExM || hitMemM);
                hazM    = idValid && (rawM || (idUsesFlags && mEx[k].s));
                if (eStall) eFreeze = 1;
                else if (exBranchTaken) begin eFlushIF = 1; eFlushID = 1; end
                else if (hazM) begin eFreeze = 1; eFlushID = 1; end
                eErr = mErr[k];
                eCnt = mCnt[k];
            end
            check("freezeIF",   k, {15'd0, aFreeze},  {15'd0, eFreeze});
            check("flushIF",    k, {15'd0, aFlushIF}, {15'd0, eFlushIF});
            check("flushID",    k, {15'd0, aFlushID}, {15'd0, eFlushID});
            check("stallAll",   k, {15'd0, aStall},   {15'd0, eStall});
            check("memReq",     k, {15'd0, aReq},     {15'd0, eReq});
            check("memErr",     k, {15'd0, aErr},     {15'd0, eErr});
            check("stallCount", k, aCnt, eCnt[15:0]);
            if (rst) begin
                if (tmoM) mErr[k] = 1;
                if (eFreeze && (mCnt[k] < 65535)) mCnt[k]++;
                if (!eStall) begin
                    idSl      = {idDest, idWbEn, idMemRead, idMemWrite, idS};
                    mMem[k]   = mEx[k];
                    mEx[k]    = (eFlushID || !idValid) ? tbSlot_t'('0) : idSl;
                    mPhase[k] = 0;
                end else if (memOpM) begin
                    mPhase[k]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic setId(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic flg, input logic [3:0] d, input logic wb, input logic mr,
                         input logic mw, input logic sf);
        idValid = v; idSrc1 = s1; idSrc2 = s2; idTwoSrc = two; idUsesFlags = flg;
        idDest = d; idWbEn = wb; idMemRead = mr; idMemWrite = mw; idS = sf;
    endtask

    task automatic clearId();
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int reqN;
    int stN;

    initial begin
        rst = 1'b0;
        memReady = 1'b1;
        exBranchTaken = 1'b1;
        setId(1, 3, 0, 0, 1, 3, 1, 1, 0, 0);
        repeat (2) sample();
        check("rstFlushIF", 0, {15'd0, busA.flushIF}, 16'd0);
        check("rstFreeze", 1, {15'd0, busB.freezeIF}, 16'd0);
        check("rstStallCount", 0, busA.stallCount, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exBranchTaken = 1'b0;
        clearId();
        repeat (2) nextCycle();

        // load-use
        setId(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); nextCycle();
        setId(1, 3, 0, 0, 0, 4, 1, 0, 0, 0); sample();
        check("luFreeze", 0, {15'd0, busA.freezeIF}, 16'd1);
        check("luFlushID", 0, {15'd0, busA.flushID}, 16'd1);
        check("luFreeze", 1, {15'd0, busB.freezeIF}, 16'd1);
        nextCycle(); sample();
        check("luFlushIDc2", 0, {15'd0, busA.flushID}, 16'd0);
        check("luMemEntry", 0, {15'd0, busA.stallAll}, 16'd1);
        nextCycle(); clearId(); repeat (4) nextCycle();

        // ALU RAW
        setId(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); nextCycle();
        setId(1, 3, 0, 0, 0, 5, 1, 0, 0, 0); sample();
        check("aluC1", 0, {15'd0, busA.freezeIF}, 16'd0);
        check("aluC1", 1, {15'd0, busB.freezeIF}, 16'd1);
        nextCycle(); sample();
        check("aluC2", 0, {15'd0, busA.freezeIF}, 16'd0);
        check("aluC2", 1, {15'd0, busB.freezeIF}, 16'd1);
        nextCycle(); sample();
        check("aluC3", 1, {15'd0, busB.freezeIF}, 16'd0);
        nextCycle(); clearId(); repeat (4) nextCycle();

        // flag hazard, then the same with a taken branch
        setId(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); nextCycle();
        setId(1, 15, 0, 0, 1, 0, 0, 0, 0, 0); sample();
        check("flagFreeze", 0, {15'd0, busA.freezeIF}, 16'd1);
        check("flagFlushID", 0, {15'd0, busA.flushID}, 16'd1);
        check("flagFlushIF", 0, {15'd0, busA.flushIF}, 16'd0);
        nextCycle(); clearId(); repeat (3) nextCycle();
        setId(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); nextCycle();
        setId(1, 15, 0, 0, 1, 0, 0, 0, 0, 0); exBranchTaken = 1'b1; sample();
        check("brFlushIF", 0, {15'd0, busA.flushIF}, 16'd1);
        check("brFlushID", 0, {15'd0, busA.flushID}, 16'd1);
        check("brFreeze", 0, {15'd0, busA.freezeIF}, 16'd0);
        check("brFreeze", 1, {15'd0, busB.freezeIF}, 16'd0);
        nextCycle(); exBranchTaken = 1'b0; clearId(); repeat (3) nextCycle();

        // store with memReady low for 3 WAIT cycles
        setId(1, 2, 3, 1, 0, 0, 0, 0, 1, 0); nextCycle();
        clearId(); nextCycle();
        memReady = 1'b0; reqN = 0; stN = 0;
        for (int c = 2; c <= 7; c++) begin
            if (c == 6) memReady = 1'b1;
            sample();
            if (busA.memReq) reqN++;
            if (busA.stallAll) stN++;
            if (c < 7) nextCycle();
        end
        check("memReqCycles", 0, 16'(reqN), 16'd4);
        check("memStallCycles", 0, 16'(stN), 16'd4);
        check("memStallCount", 0, busA.stallCount, 16'd7);
        check("memStallCount", 1, busB.stallCount, 16'd9);
        repeat (3) nextCycle();

        // timeout with memReady held low, then a second load
        memReady = 1'b0;
        setId(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); nextCycle();
        clearId(); nextCycle();
        sample();
        check("toEntryStall", 0, {15'd0, busA.stallAll}, 16'd1);
        nextCycle();
        repeat (3) begin sample(); nextCycle(); end
        sample();
        check("toRelease", 0, {15'd0, busA.stallAll}, 16'd0);
        check("toReq", 0, {15'd0, busA.memReq}, 16'd1);
        check("toErrBefore", 0, {15'd0, busA.memErr}, 16'd0);
        nextCycle();
        setId(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); sample();
        check("toErr", 0, {15'd0, busA.memErr}, 16'd1);
        check("toErr", 1, {15'd0, busB.memErr}, 16'd1);
        nextCycle(); clearId(); nextCycle();
        sample();
        check("ld2Stall", 0, {15'd0, busA.stallAll}, 16'd1);
        nextCycle(); memReady = 1'b1; sample();
        check("ld2Release", 0, {15'd0, busA.stallAll}, 16'd0);
        check("ld2ErrSticky", 0, {15'd0, busA.memErr}, 16'd1);
        repeat (3) nextCycle();

        // reset asserted in the middle of WAIT
        memReady = 1'b0;
        setId(1, 2, 3, 1, 0, 0, 0, 0, 1, 0); nextCycle();
        clearId(); nextCycle();
        sample(); nextCycle();
        sample();
        check("rwReqBefore", 0, {15'd0, busA.memReq}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rwReqAsync", 0, {15'd0, busA.memReq}, 16'd0);
        check("rwStallAsync", 0, {15'd0, busA.stallAll}, 16'd0);
        check("rwReqAsync", 1, {15'd0, busB.memReq}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        memReady = 1'b1;
        sample();
        check("rwStallCount", 0, busA.stallCount, 16'd0);
        check("rwStallCount", 1, busB.stallCount, 16'd0);
        check("rwErrCleared", 0, {15'd0, busA.memErr}, 16'd0);
        check("rwSlotsBubble", 0, {15'd0, busA.stallAll}, 16'd0);
        nextCycle();

        // randomized traffic with small register range to provoke hits
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 399) != 0);
            idValid       = ($urandom_range(0, 9) != 0);
            idSrc1        = 4'($urandom_range(0, 3));
            idSrc2        = 4'($urandom_range(0, 3));
            idDest        = 4'($urandom_range(0, 3));
            idTwoSrc      = 1'($urandom_range(0, 1));
            idUsesFlags   = ($urandom_range(0, 3) == 0);
            idWbEn        = 1'($urandom_range(0, 1));
            idMemRead     = ($urandom_range(0, 4) == 0);
            idMemWrite    = ($urandom_range(0, 5) == 0);
            idS           = ($urandom_range(0, 3) == 0);
            exBranchTaken = ($urandom_range(0, 9) == 0);
            memReady      = 1'($urandom_range(0, 1));
            nextCycle();
        end
        rst = 1'b1;
        repeat (2) nextCycle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
